greg_file: RTL and testbench
============================

Name: greg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS CPU datapath.
- Two combinational read ports (rs/rt operands) and one synchronous write port (writeback).
- Register 0 is hardwired to zero.
- Asynchronous active-low reset clears every register.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH (32 entries)

Ports:
- clk  input  1  clock; writes occur on the rising edge
- rst_n  input  1  asynchronous active-low reset; clears all registers
- reg_wr  input  1  write enable, sampled on the rising edge of clk
- read1  input  ADDR_WIDTH  read port 1 register index
- read2  input  ADDR_WIDTH  read port 2 register index
- wr_num  input  ADDR_WIDTH  write register index
- wr_data  input  DATA_WIDTH  write data
- data1  output  DATA_WIDTH  contents of register read1
- data2  output  DATA_WIDTH  contents of register read2

Behaviour:
- Reset:
  - rst_n low clears all 32 registers to 0 immediately, with no clock required.
  - data1 and data2 read 0 while rst_n is low.
  - Writes are blocked while rst_n is low.
  - Deassertion is synchronised by the user; the first write can occur on the first rising edge with rst_n high.
- Write:
  - On the rising edge of clk, with rst_n high, reg_wr=1 and wr_num!=0: the register at wr_num takes wr_data.
  - Write latency is one edge; the new value is visible on the read ports right after that edge.
- Register 0:
  - Writes with wr_num=0 are ignored.
  - Register 0 always reads 0, including after an attempted write.
- reg_wr=0: no register changes, whatever wr_num and wr_data are.
- Read:
  - Purely combinational, zero latency.
  - data1 = reg[read1], data2 = reg[read2].
  - Outputs update within the same cycle when read1, read2 or the register contents change.
- No write-to-read bypass:
  - When read address = wr_num in the same cycle, the read port shows the old value until the clock edge, then the new value.
  - Single-cycle MIPS writeback timing relies on this edge behaviour.
- Both read ports may address the same register, including 0; each returns the same value independently.
- Widths are exact; no sign extension or truncation inside the block.
- Reset asserted mid-cycle, coincident with a write edge: reset wins and the register stays 0.
- No X propagation: every register is defined after reset.
- Implementation: flop array with async clear; register 0 need not be stored and may be a constant zero.

Test Plan:
- Reset, then reg_wr=0, read1=0, read2=0 -> data1=0, data2=0; sweep read1 over 0..31 -> all read 0.
- reg_wr=1, wr_num=0, wr_data=2333, one clock edge; read1=0 -> data1=0 (register 0 write ignored).
- reg_wr=1, wr_num=1, wr_data=2333, one edge; then reg_wr=0, read1=1, read2=2, wr_num=2, wr_data=2333, one edge -> data1=2333, data2=0 (no write with reg_wr=0).
- Write 0xDEADBEEF to r31 and 0x12345678 to r5; read1=31, read2=5 -> data1=0xDEADBEEF, data2=0x12345678; read1=read2=31 -> both 0xDEADBEEF.
- read1=7 while writing 0xA5A5A5A5 to r7 -> data1 holds the old value (0) before the edge and 0xA5A5A5A5 after the edge.
- After registers hold nonzero data, pulse rst_n low between clock edges -> data1 and data2 go to 0 immediately; all registers read 0 afterward.

Source files
------------

// File: rtl/greg_file_if.sv
// Register file access bundle: two read ports and one write port.
// The datapath (master) drives indices and write data; the register
// file (slave) returns the read operands combinationally.
interface greg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_wr;
    logic [ADDR_WIDTH-1:0] read1;
    logic [ADDR_WIDTH-1:0] read2;
    logic [ADDR_WIDTH-1:0] wr_num;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;

    modport master (
        output reg_wr,
        output read1,
        output read2,
        output wr_num,
        output wr_data,
        input  data1,
        input  data2
    );

    modport slave (
        input  reg_wr,
        input  read1,
        input  read2,
        input  wr_num,
        input  wr_data,
        output data1,
        output data2
    );
endinterface

// File: rtl/greg_file.sv
// MIPS general-purpose register file.
// 2**ADDR_WIDTH entries of DATA_WIDTH bits, two combinational read ports,
// one write port committed on the rising clock edge. Register 0 is not
// stored: it is a constant zero and writes to it are dropped.
// There is deliberately no write-to-read bypass; a read of the register
// being written shows the old value until the edge.
module greg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    greg_file_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entries 1..DEPTH-1 only; entry 0 is synthesised as a constant.
    logic [DATA_WIDTH-1:0] mem [1:DEPTH-1];

    logic [DATA_WIDTH-1:0] rd1_val;
    logic [DATA_WIDTH-1:0] rd2_val;

    // Writeback: async clear of every entry, otherwise one-hot write decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.reg_wr) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (bus.wr_num == ADDR_WIDTH'(i)) begin
                    mem[i] <= bus.wr_data;
                end
            end
        end
    end

    // Operand read: index 0 forced to zero, everything else straight from
    // the array. Cleared flops make both ports read 0 during reset.
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.read1 == ADDR_WIDTH'(i)) begin
                rd1_val = mem[i];
            end
            if (bus.read2 == ADDR_WIDTH'(i)) begin
                rd2_val = mem[i];
            end
        end
    end

    assign bus.data1 = rd1_val;
    assign bus.data2 = rd2_val;

endmodule

// File: tb/tb_greg_file.sv
// Scoreboard bench for greg_file: stimulus pushes expected read values,
// a monitor pops and compares them on the falling clock edge.
module tb_greg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        string         name;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    greg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    greg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_rd(input string name, input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input logic we, input logic [AW-1:0] num, input logic [DW-1:0] d);
        bus.reg_wr  = we;
        bus.wr_num  = num;
        bus.wr_data = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.read1 = a1;
        bus.read2 = a2;
    endtask

    // Monitor: compare every pending expectation against the read ports.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.data1 !== e.e1 || bus.data2 !== e.e2) begin
                    n_fail++;
                    $display("FAIL %s: data1=%h data2=%h expected data1=%h data2=%h",
                             e.name, bus.data1, bus.data2, e.e1, e.e2);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_wr(1'b0, '0, '0);
        set_rd('0, '0);

        // Reset state, and writes blocked during reset.
        step();
        expect_rd("reset_r0", 32'd0, 32'd0);
        set_wr(1'b1, 5'd3, 32'hFFFF_FFFF);
        step();
        set_wr(1'b0, '0, '0);
        set_rd(5'd3, 5'd3);
        expect_rd("wr_blocked_in_reset", 32'd0, 32'd0);

        // Release reset between edges; sweep all entries.
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            set_rd(AW'(i), AW'(31 - i));
            expect_rd($sformatf("post_reset_sweep_%0d", i), 32'd0, 32'd0);
        end

        // Write to register 0 is dropped.
        step();
        set_wr(1'b1, 5'd0, 32'd2333);
        step();
        set_wr(1'b0, '0, '0);
        set_rd(5'd0, 5'd0);
        expect_rd("r0_write_ignored", 32'd0, 32'd0);

        // r1 write, then reg_wr=0 to r2 must not change it.
        step();
        set_wr(1'b1, 5'd1, 32'd2333);
        step();
        set_wr(1'b0, 5'd2, 32'd2333);
        set_rd(5'd1, 5'd2);
        step();
        expect_rd("r1_written_r2_untouched", 32'd2333, 32'd0);

        // Two full-width patterns, read independently and on both ports.
        set_wr(1'b1, 5'd31, 32'hDEAD_BEEF);
        step();
        set_wr(1'b1, 5'd5, 32'h1234_5678);
        step();
        set_wr(1'b0, '0, '0);
        set_rd(5'd31, 5'd5);
        expect_rd("r31_r5", 32'hDEAD_BEEF, 32'h1234_5678);
        step();
        set_rd(5'd31, 5'd31);
        expect_rd("both_ports_r31", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        step();
        set_rd(5'd0, 5'd0);
        expect_rd("both_ports_r0", 32'd0, 32'd0);

        // No bypass: old value before the edge, new value after it.
        step();
        set_rd(5'd7, 5'd31);
        set_wr(1'b1, 5'd7, 32'hA5A5_A5A5);
        expect_rd("r7_before_edge", 32'd0, 32'hDEAD_BEEF);
        step();
        set_wr(1'b0, '0, '0);
        expect_rd("r7_after_edge", 32'hA5A5_A5A5, 32'hDEAD_BEEF);

        // All-ones, overwrite, and neighbours untouched.
        step();
        set_wr(1'b1, 5'd10, 32'hFFFF_FFFF);
        step();
        set_wr(1'b1, 5'd31, 32'h0000_0001);
        step();
        set_wr(1'b0, '0, '0);
        set_rd(5'd10, 5'd31);
        expect_rd("r10_ones_r31_overwrite", 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        set_rd(5'd11, 5'd30);
        expect_rd("neighbours_zero", 32'd0, 32'd0);
        step();
        set_rd(5'd5, 5'd1);
        expect_rd("r5_r1_retained", 32'h1234_5678, 32'd2333);

        // Reset pulse between edges, with a write held across an edge.
        step();
        set_rd(5'd5, 5'd10);
        set_wr(1'b1, 5'd9, 32'h5555_AAAA);
        rst_n = 1'b0;
        expect_rd("reset_immediate", 32'd0, 32'd0);
        step();
        set_rd(5'd9, 5'd7);
        expect_rd("reset_beats_write", 32'd0, 32'd0);
        step();
        set_wr(1'b0, '0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            set_rd(AW'(i), AW'(31 - i));
            expect_rd($sformatf("after_reset_pulse_%0d", i), 32'd0, 32'd0);
        end

        step();
        step();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
